// File: rtl/wb_vmon_pkg.sv
// Shared types and helpers for the vmon Wishbone write-capture monitor.
// Covers the byte-lane select codes, the queued message format and the SEL-to-message decode.
package wb_vmon_pkg;

   localparam int unsigned MSG_DATA_W = 32;
   localparam int unsigned MSG_SIZE_W = 3;
   localparam int unsigned SEL_W      = 4;

   localparam logic [SEL_W-1:0] SEL_B0 = 4'b0001;
   localparam logic [SEL_W-1:0] SEL_B1 = 4'b0010;
   localparam logic [SEL_W-1:0] SEL_B2 = 4'b0100;
   localparam logic [SEL_W-1:0] SEL_B3 = 4'b1000;
   localparam logic [SEL_W-1:0] SEL_H0 = 4'b0011;
   localparam logic [SEL_W-1:0] SEL_H1 = 4'b1100;
   localparam logic [SEL_W-1:0] SEL_WD = 4'b1111;

   typedef struct packed {
      logic [MSG_DATA_W-1:0] data;
      logic [MSG_SIZE_W-1:0] size;
   } vmon_msg_t;

   typedef struct packed {
      logic      valid;
      vmon_msg_t msg;
   } vmon_sel_msg_t;

   // Packs the enabled lanes LSB-first; valid=0 for any unsupported lane pattern.
   function automatic vmon_sel_msg_t sel_to_msg(input logic [SEL_W-1:0]      sel,
                                                input logic [MSG_DATA_W-1:0] dat);
      vmon_sel_msg_t r;
      r       = '0;
      r.valid = 1'b1;
      case (sel)
         SEL_B0:  begin r.msg.data = {24'h0, dat[7:0]};   r.msg.size = 3'd1; end
         SEL_B1:  begin r.msg.data = {24'h0, dat[15:8]};  r.msg.size = 3'd1; end
         SEL_B2:  begin r.msg.data = {24'h0, dat[23:16]}; r.msg.size = 3'd1; end
         SEL_B3:  begin r.msg.data = {24'h0, dat[31:24]}; r.msg.size = 3'd1; end
         SEL_H0:  begin r.msg.data = {16'h0, dat[15:0]};  r.msg.size = 3'd2; end
         SEL_H1:  begin r.msg.data = {16'h0, dat[31:16]}; r.msg.size = 3'd2; end
         SEL_WD:  begin r.msg.data = dat;                 r.msg.size = 3'd4; end
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/wb_vmon_write_capture_fifo.sv
// Message FIFO with a registered head entry; the head holds the last popped entry when empty.
module vmon_msg_fifo
   import wb_vmon_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      push_i,
   input  vmon_msg_t wdata_i,
   input  logic      pop_i,
   output vmon_msg_t rdata_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   vmon_msg_t        mem_q [DEPTH];
   vmon_msg_t        head_q, head_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   logic             full, push_en, pop_en;

   assign full = (count_q == CNT_W'(DEPTH));

   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   always_comb begin
      pop_en   = pop_i & valid_q;
      push_en  = push_i & (~full | pop_en);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      valid_d = (count_d != '0);
      if (valid_d) begin
         if (push_en && (rd_ptr_d == wr_ptr_q)) head_d = wdata_i;
         else                                   head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         head_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         head_q   <= head_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = head_q;
   assign full_o  = full;
   assign empty_o = ~valid_q;

endmodule

// File: rtl/wb_vmon_write_capture.sv
// Passive Wishbone write monitor: captures writes to one message address into a FIFO
// and presents them on the vmon m2h valid/ready stream.
module wb_vmon_write_capture
   import wb_vmon_pkg::*;
#(
   parameter int unsigned              WB_ADDR_WIDTH = 32,
   parameter int unsigned              WB_DATA_WIDTH = 32,
   parameter logic [WB_ADDR_WIDTH-1:0] ADDRESS       = 'h0000_0000,
   parameter int unsigned              FIFO_DEPTH    = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [WB_ADDR_WIDTH-1:0]   ADR,
   input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
   input  logic                       CYC,
   input  logic                       STB,
   input  logic                       ACK,
   input  logic                       WE,
   input  logic                       ERR,
   input  logic [WB_DATA_WIDTH/8-1:0] SEL,
   output logic                       msg_valid,
   input  logic                       msg_ready,
   output logic [MSG_DATA_W-1:0]      msg_data,
   output logic [MSG_SIZE_W-1:0]      msg_size,
   output logic                       overflow,
   output logic                       sel_err
);

   localparam int unsigned ADR_LSB = $clog2(WB_DATA_WIDTH) - 1;

   if (WB_DATA_WIDTH != 32) begin : g_bad_data_width
      $error("wb_vmon_write_capture: WB_DATA_WIDTH must be 32");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("wb_vmon_write_capture: FIFO_DEPTH must be a power of two >= 2");
   end

   vmon_sel_msg_t sel_msg;
   vmon_msg_t     head;
   logic          addr_eq, hit, push, pop, fifo_full, fifo_empty;
   logic          sel_err_q, sel_err_d, overflow_q, overflow_d;
   logic          unused_c;

   // Match window is one data-word group above the lane bits (16 bytes on a 32-bit bus).
   assign addr_eq = (ADR[WB_ADDR_WIDTH-1:ADR_LSB] == ADDRESS[WB_ADDR_WIDTH-1:ADR_LSB]);
   assign hit     = CYC & STB & ACK & WE & addr_eq;
   assign sel_msg = sel_to_msg(SEL, DAT_W);
   assign push    = hit & sel_msg.valid;
   assign pop     = msg_valid & msg_ready;

   always_comb begin
      sel_err_d  = hit & ~sel_msg.valid;
      overflow_d = overflow_q | (push & fifo_full & ~pop);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         sel_err_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         sel_err_q  <= sel_err_d;
         overflow_q <= overflow_d;
      end
   end

   vmon_msg_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_i),
      .push_i  (push),
      .wdata_i (sel_msg.msg),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign msg_valid = ~fifo_empty;
   assign msg_data  = head.data;
   assign msg_size  = head.size;
   assign overflow  = overflow_q;
   assign sel_err   = sel_err_q;
   assign unused_c  = ^{ERR, ADR[ADR_LSB-1:0]};

endmodule

// File: tb/tb_wb_vmon_write_capture.sv
// Scoreboard bench for wb_vmon_write_capture: directed test-plan cases then random traffic,
// checked against a queue-based model of the message FIFO.
module tb_wb_vmon_write_capture;

   localparam int unsigned DEPTH   = 4;
   localparam logic [31:0] ADDRESS = 32'h1000_0040;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] ADR, DAT_W;
   logic        CYC, STB, ACK, WE, ERR;
   logic [3:0]  SEL;
   logic        msg_valid, msg_ready;
   logic [31:0] msg_data;
   logic [2:0]  msg_size;
   logic        overflow, sel_err;

   always #5 clk_i = ~clk_i;

   wb_vmon_write_capture #(
      .WB_ADDR_WIDTH (32),
      .WB_DATA_WIDTH (32),
      .ADDRESS       (ADDRESS),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .ADR       (ADR),
      .DAT_W     (DAT_W),
      .CYC       (CYC),
      .STB       (STB),
      .ACK       (ACK),
      .WE        (WE),
      .ERR       (ERR),
      .SEL       (SEL),
      .msg_valid (msg_valid),
      .msg_ready (msg_ready),
      .msg_data  (msg_data),
      .msg_size  (msg_size),
      .overflow  (overflow),
      .sel_err   (sel_err)
   );

   typedef struct {
      logic [31:0] data;
      logic [2:0]  size;
   } exp_msg_t;

   typedef struct {
      int unsigned edge_no;
      logic        valid;
      logic        sel_err;
      logic        ovf;
      logic        rst;
   } exp_stat_t;

   exp_msg_t    exp_q[$];
   exp_stat_t   stat_q[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned edge_cnt = 0;
   int          model_count = 0;
   logic        model_ovf = 1'b0;

   always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Byte-lane table: which bytes of the write become the message, and how many.
   function automatic bit model_decode(input logic [3:0] sel, input logic [31:0] dat,
                                       output logic [31:0] d, output logic [2:0] s);
      d = 32'h0;
      s = 3'd0;
      case (sel)
         4'b0001: begin d = dat & 32'hFF;          s = 3'd1; end
         4'b0010: begin d = (dat >> 8) & 32'hFF;   s = 3'd1; end
         4'b0100: begin d = (dat >> 16) & 32'hFF;  s = 3'd1; end
         4'b1000: begin d = dat >> 24;             s = 3'd1; end
         4'b0011: begin d = dat & 32'hFFFF;        s = 3'd2; end
         4'b1100: begin d = dat >> 16;             s = 3'd2; end
         4'b1111: begin d = dat;                   s = 3'd4; end
         default: return 1'b0;
      endcase
      return 1'b1;
   endfunction

   // Applies one cycle of inputs and records what the model expects after the next edge.
   task automatic drive(input bit rst, input bit cyc, input bit stb, input bit ack, input bit we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input bit rdy);
      exp_stat_t   st;
      exp_msg_t    em;
      logic [31:0] d;
      logic [2:0]  s;
      bit          ok, hit, pop;
      @(posedge clk_i);
      #2;
      rst_i = rst; CYC = cyc; STB = stb; ACK = ack; WE = we;
      ADR = adr; DAT_W = dat; SEL = sel; msg_ready = rdy;
      ERR = 1'($urandom_range(0, 1));
      st.edge_no = edge_cnt + 1;
      if (!rst) begin
         model_count = 0;
         model_ovf   = 1'b0;
         exp_q.delete();
         st.valid = 1'b0; st.sel_err = 1'b0; st.ovf = 1'b0; st.rst = 1'b1;
      end else begin
         hit = cyc && stb && ack && we && ((adr >> 4) == (ADDRESS >> 4));
         ok  = model_decode(sel, dat, d, s);
         pop = rdy && (model_count > 0);
         st.sel_err = hit && !ok;
         if (hit && ok) begin
            if ((model_count < DEPTH) || pop) begin
               em.data = d;
               em.size = s;
               exp_q.push_back(em);
               model_count++;
            end else begin
               model_ovf = 1'b1;
            end
         end
         if (pop) model_count--;
         st.valid = (model_count > 0);
         st.ovf   = model_ovf;
         st.rst   = 1'b0;
      end
      stat_q.push_back(st);
   endtask

   task automatic idle(input bit rdy);
      drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, rdy);
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input bit rdy);
      drive(1, 1, 1, 1, 1, adr, dat, sel, rdy);
   endtask

   // Monitor: per-cycle status checks plus in-order message checks on every handshake.
   initial begin
      exp_stat_t   st;
      exp_msg_t    em;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_data  = 32'h0;
      logic [2:0]  prev_size  = 3'd0;
      forever begin
         @(negedge clk_i);
         if (stat_q.size() > 0 && stat_q[0].edge_no == edge_cnt) begin
            st = stat_q.pop_front();
            check("msg_valid", 32'(msg_valid), 32'(st.valid));
            check("sel_err",   32'(sel_err),   32'(st.sel_err));
            check("overflow",  32'(overflow),  32'(st.ovf));
            if (st.rst) begin
               check("msg_data_after_reset", msg_data, 32'h0);
               check("msg_size_after_reset", 32'(msg_size), 32'h0);
            end
         end
         if (prev_stall && msg_valid === 1'b1) begin
            check("hold_data", msg_data, prev_data);
            check("hold_size", 32'(msg_size), 32'(prev_size));
         end
         if (rst_i === 1'b1 && msg_valid === 1'b1 && msg_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_msg: got data %h size %0d, expected no entry", msg_data, msg_size);
            end else begin
               em = exp_q.pop_front();
               check("msg_data", msg_data, em.data);
               check("msg_size", 32'(msg_size), 32'(em.size));
            end
         end
         prev_stall = (rst_i === 1'b1) && (msg_valid === 1'b1) && (msg_ready === 1'b0);
         prev_data  = msg_data;
         prev_size  = msg_size;
      end
   end

   logic [3:0] sel_tab [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0011, 4'b1100, 4'b1111, 4'b0101};

   initial begin
      logic [31:0] adr, base;
      logic [3:0]  sel;
      int          rdy_pct;
      rst_i = 1'b0; CYC = 1'b0; STB = 1'b0; ACK = 1'b0; WE = 1'b0; ERR = 1'b0;
      ADR = 32'h0; DAT_W = 32'h0; SEL = 4'h0; msg_ready = 1'b0;
      base = ADDRESS & 32'hFFFF_FFF0;

      drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0);
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0);

      // Word write, single byte lane, upper half-word.
      wr(ADDRESS, 32'hDDCCBBAA, 4'b1111, 0);
      idle(1);
      wr(ADDRESS, 32'h00550000, 4'b0100, 1);
      idle(1);
      wr(ADDRESS, 32'h12340000, 4'b1100, 1);
      idle(1);

      // Outside the window, read, no ACK; then a hit at +8 inside the window.
      wr(ADDRESS + 32'h10, 32'h11111111, 4'b1111, 1);
      drive(1, 1, 1, 1, 0, ADDRESS, 32'h22222222, 4'b1111, 1);
      drive(1, 1, 1, 0, 1, ADDRESS, 32'h33333333, 4'b1111, 1);
      wr(ADDRESS + 32'h8, 32'h44444444, 4'b0011, 1);
      idle(1);

      wr(ADDRESS, 32'h66666666, 4'b0101, 1);
      idle(1);
      idle(1);

      // Fill past capacity, then push while full with a pop in the same cycle.
      for (int i = 0; i < 5; i++) wr(ADDRESS, 32'hA0A0_0000 + 32'(i), 4'b1111, 0);
      idle(0);
      wr(ADDRESS, 32'hBEEF_0001, 4'b0011, 1);
      for (int i = 0; i < DEPTH + 2; i++) idle(1);

      // Queue entries then reset mid-stream.
      wr(ADDRESS, 32'hC0C0_0001, 4'b1111, 0);
      wr(ADDRESS, 32'hC0C0_0002, 4'b1111, 0);
      drive(0, 1, 1, 1, 1, ADDRESS, 32'hC0C0_0003, 4'b1111, 0);
      idle(1);
      idle(1);

      // Random traffic with alternating ready pressure and rare resets.
      rdy_pct = 80;
      for (int i = 0; i < 800; i++) begin
         if (i % 60 == 0) rdy_pct = (rdy_pct == 80) ? 15 : 80;
         adr = ($urandom_range(0, 3) == 0) ? $urandom : base + 32'($urandom_range(0, 31));
         sel = ($urandom_range(0, 7) == 0) ? 4'($urandom) : sel_tab[$urandom_range(0, 7)];
         drive($urandom_range(0, 99) >= 2,
               $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
               $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0,
               adr, $urandom, sel, $urandom_range(0, 99) < rdy_pct);
      end

      for (int i = 0; i < DEPTH + 4; i++) idle(1);
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      check("exp_queue_drained", 32'(exp_q.size()), 32'h0);
      check("status_queue_drained", 32'(stat_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
